// File: rtl/scope_pkg.sv
// -----------------------------------------------------------------------------
// scope_pkg
// Shared types and constants for the scope acquisition path.
//   scope_acq_state_t : acquisition FSM state encoding (IDLE, PRE, ARM, POST)
//   SCOPE_TMR_W       : width of the optional cycle timestamp counter
// -----------------------------------------------------------------------------
package scope_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ARM  = 2'd2,
    POST = 2'd3
  } scope_acq_state_t;

  localparam int SCOPE_TMR_W = 64;

endpackage

// File: rtl/axi4_stream_if.sv
// -----------------------------------------------------------------------------
// axi4_stream_if
// Minimal AXI4-Stream bundle carrying signed sample data.
//   DN     : TDATA width
//   s      : source side (drives TDATA/TLAST/TVALID, receives TREADY)
//   d      : destination side (receives TDATA/TLAST/TVALID, drives TREADY)
// -----------------------------------------------------------------------------
interface axi4_stream_if #(
  parameter int DN = 14
);

  logic signed [DN-1:0] TDATA;
  logic                 TLAST;
  logic                 TVALID;
  logic                 TREADY;

  modport s (output TDATA, output TLAST, output TVALID, input TREADY);
  modport d (input TDATA, input TLAST, input TVALID, output TREADY);

endinterface

// File: rtl/axi4_stream_reg.sv
// -----------------------------------------------------------------------------
// axi4_stream_reg
// One-deep registered stream output stage.
//   clk_i    : clock
//   rst_i    : synchronous flush (active-high), empties the register
//   load_i   : capture data_i/last_i this cycle (only asserted when the
//              upstream side sees ready, i.e. register empty or draining)
//   data_i   : sample to capture
//   last_i   : TLAST to capture
//   tready_i : downstream ready
//   tdata_o  : registered TDATA
//   tlast_o  : registered TLAST
//   tvalid_o : registered TVALID
// -----------------------------------------------------------------------------
module axi4_stream_reg #(
  parameter int DW = 14
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic signed [DW-1:0] data_i,
  input  logic                 last_i,
  input  logic                 tready_i,
  output logic signed [DW-1:0] tdata_o,
  output logic                 tlast_o,
  output logic                 tvalid_o
);

  logic signed [DW-1:0] data_q;
  logic                 last_q;
  logic                 vld_q;

  // Output stage: load wins over drain so a sample can be replaced in the
  // same cycle the previous one is accepted downstream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
      last_q <= last_i;
    end else if (tready_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign tdata_o  = data_q;
  assign tlast_o  = last_q;
  assign tvalid_o = vld_q;

endmodule

// File: rtl/scope_acq.sv
// -----------------------------------------------------------------------------
// scope_acq
// Acquisition controller downstream of the scope edge detector. Collects
// cfg_pre pre-trigger samples (more while armed), then cfg_pst+1 post-trigger
// samples, forwarding only acquired samples through a registered stream and
// marking the final post sample with TLAST.
//
// Ports
//   ACLK, ARESET      : clock, synchronous active-high reset
//   ctl_rst           : soft reset (same effect as ARESET)
//   ctl_acq / ctl_stp : start / stop acquisition pulses
//   ctl_trg           : trigger pulse from the edge detector
//   cfg_con           : continuous re-arm after completion
//   cfg_pre, cfg_pst  : pre-trigger count, post-trigger count (minus one)
//   sts_acq/arm/trg   : state flags (not IDLE / ARM / POST)
//   sts_pre, sts_pst  : transferred pre (saturating) and post sample counts
//   sti, sto          : input and output sample streams
//
// Optional feature: define SCOPE_ACQ_TIMESTAMP_EN to add a free-running cycle
// counter and the sts_tmr_trg / sts_tmr_stp capture outputs.
// -----------------------------------------------------------------------------
module scope_acq
  import scope_pkg::*;
#(
  parameter int DWI = 14,
  parameter int CW  = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   ctl_rst,
  input  logic                   ctl_acq,
  input  logic                   ctl_stp,
  input  logic                   ctl_trg,
  input  logic                   cfg_con,
  input  logic [CW-1:0]          cfg_pre,
  input  logic [CW-1:0]          cfg_pst,
  output logic                   sts_acq,
  output logic                   sts_arm,
  output logic                   sts_trg,
  output logic [CW-1:0]          sts_pre,
  output logic [CW-1:0]          sts_pst,
`ifdef SCOPE_ACQ_TIMESTAMP_EN
  output logic [SCOPE_TMR_W-1:0] sts_tmr_trg,
  output logic [SCOPE_TMR_W-1:0] sts_tmr_stp,
`endif
  axi4_stream_if.d               sti,
  axi4_stream_if.s               sto
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  scope_acq_state_t      state_q, state_d;
  logic [CW-1:0]         pre_q, pre_d;
  logic [CW-1:0]         pst_q, pst_d;
  logic                  rst;
  logic                  in_rdy;
  logic                  xfer;
  logic                  load;
  logic                  last;
  logic signed [DWI-1:0] out_data;
  logic                  out_last;
  logic                  out_vld;

  assign rst = ARESET | ctl_rst;

  // In IDLE the input is drained and discarded; otherwise it follows the
  // output register's capacity.
  assign in_rdy     = (state_q == IDLE) | ~out_vld | sto.TREADY;
  assign sti.TREADY = in_rdy;
  assign xfer       = sti.TVALID & in_rdy;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    pst_d   = pst_q;
    load    = 1'b0;
    last    = 1'b0;
    if ((state_q != IDLE) && ctl_stp) begin
      // Stop drops the current input sample and freezes counters.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ctl_acq) begin
            state_d = PRE;
            pre_d   = '0;
            pst_d   = '0;
          end
        end
        PRE: begin
          if (xfer) begin
            load  = 1'b1;
            pre_d = sat_inc(pre_q);
          end
          // cfg_pre==0 needs no pre samples: leave after a single cycle.
          if ((cfg_pre == '0) || (xfer && (pre_d == cfg_pre))) begin
            state_d = ARM;
          end
        end
        ARM: begin
          if (xfer) begin
            load  = 1'b1;
            pre_d = sat_inc(pre_q);
          end
          if (ctl_trg) begin
            state_d = POST;
          end
        end
        POST: begin
          if (xfer) begin
            load = 1'b1;
            if (pst_q == cfg_pst) begin
              last = 1'b1;
              if (cfg_con) begin
                state_d = PRE;
                pre_d   = '0;
                pst_d   = '0;
              end else begin
                state_d = IDLE;
              end
            end else begin
              pst_d = pst_q + CNT_ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      pst_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      pst_q   <= pst_d;
    end
  end

  axi4_stream_reg #(
    .DW (DWI)
  ) u_out (
    .clk_i    (ACLK),
    .rst_i    (rst),
    .load_i   (load),
    .data_i   (sti.TDATA),
    .last_i   (last),
    .tready_i (sto.TREADY),
    .tdata_o  (out_data),
    .tlast_o  (out_last),
    .tvalid_o (out_vld)
  );

  assign sto.TDATA  = out_data;
  assign sto.TLAST  = out_last;
  assign sto.TVALID = out_vld;

  assign sts_acq = (state_q != IDLE);
  assign sts_arm = (state_q == ARM);
  assign sts_trg = (state_q == POST);
  assign sts_pre = pre_q;
  assign sts_pst = pst_q;

`ifdef SCOPE_ACQ_TIMESTAMP_EN
  logic [SCOPE_TMR_W-1:0] tmr_q;
  logic [SCOPE_TMR_W-1:0] tmr_trg_q;
  logic [SCOPE_TMR_W-1:0] tmr_stp_q;

  always_ff @(posedge ACLK) begin
    if (rst) begin
      tmr_q     <= '0;
      tmr_trg_q <= '0;
      tmr_stp_q <= '0;
    end else begin
      tmr_q <= tmr_q + SCOPE_TMR_W'(1);
      // Accepted trigger: ARM with ctl_trg and no overriding stop.
      if ((state_q == ARM) && ctl_trg && !ctl_stp) begin
        tmr_trg_q <= tmr_q;
      end
      if ((state_q != IDLE) && (state_d == IDLE)) begin
        tmr_stp_q <= tmr_q;
      end
    end
  end

  assign sts_tmr_trg = tmr_trg_q;
  assign sts_tmr_stp = tmr_stp_q;
`endif

endmodule

// File: tb/tb_scope_acq.sv
// -----------------------------------------------------------------------------
// tb_scope_acq
// Directed bench for scope_acq. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_scope_acq;
  import scope_pkg::*;

  localparam int DWI = 14;
  localparam int CW  = 32;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          ctl_rst, ctl_acq, ctl_stp, ctl_trg, cfg_con;
  logic [CW-1:0] cfg_pre, cfg_pst;
  logic          sts_acq, sts_arm, sts_trg;
  logic [CW-1:0] sts_pre, sts_pst;
`ifdef SCOPE_ACQ_TIMESTAMP_EN
  logic [SCOPE_TMR_W-1:0] sts_tmr_trg, sts_tmr_stp;
`endif

  axi4_stream_if #(.DN(DWI)) sti ();
  axi4_stream_if #(.DN(DWI)) sto ();

  always #5 ACLK = ~ACLK;

  scope_acq #(.DWI(DWI), .CW(CW)) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .ctl_rst (ctl_rst),
    .ctl_acq (ctl_acq),
    .ctl_stp (ctl_stp),
    .ctl_trg (ctl_trg),
    .cfg_con (cfg_con),
    .cfg_pre (cfg_pre),
    .cfg_pst (cfg_pst),
    .sts_acq (sts_acq),
    .sts_arm (sts_arm),
    .sts_trg (sts_trg),
    .sts_pre (sts_pre),
    .sts_pst (sts_pst),
`ifdef SCOPE_ACQ_TIMESTAMP_EN
    .sts_tmr_trg (sts_tmr_trg),
    .sts_tmr_stp (sts_tmr_stp),
`endif
    .sti     (sti),
    .sto     (sto)
  );

  int total = 0;
  int bad   = 0;
  int seq   = 0;
  int got_d[$];
  bit got_l[$];
  bit trg_seen    = 1'b0;
  bit pre_on_last = 1'b0;
  bit stab_on     = 1'b0;
  bit p_stall     = 1'b0;
  logic signed [DWI-1:0] p_data;
  logic p_last;
  bit last_in_x;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit in_x;
    @(negedge ACLK);
    in_x = sti.TVALID & sti.TREADY;
    if (sts_trg) trg_seen = 1'b1;
    if (stab_on && p_stall) begin
      chk("stall_vld", 64'(sto.TVALID), 64'(1));
      chk("stall_data", 64'(sto.TDATA), 64'(p_data));
      chk("stall_last", 64'(sto.TLAST), 64'(p_last));
    end
    p_stall = sto.TVALID & ~sto.TREADY;
    p_data  = sto.TDATA;
    p_last  = sto.TLAST;
    if (sto.TVALID && sto.TREADY) begin
      got_d.push_back(int'(sto.TDATA));
      got_l.push_back(sto.TLAST);
      if (pre_on_last && sto.TLAST)
        chk("pre_after_last", 64'({sts_acq, sts_arm, sts_trg}), 64'(3'b100));
    end
    last_in_x = in_x;
    @(posedge ACLK);
    #1;
    if (in_x) seq++;
    sti.TDATA = DWI'(seq);
  endtask

  function automatic int n_last();
    int n = 0;
    foreach (got_l[i]) n += int'(got_l[i]);
    return n;
  endfunction

  int  base;
  int  post_first;
  bit  trg_done;
  bit  done;

  initial begin
    ARESET = 1'b1; ctl_rst = 1'b0; ctl_acq = 1'b0; ctl_stp = 1'b0; ctl_trg = 1'b0;
    cfg_con = 1'b0; cfg_pre = '0; cfg_pst = '0;
    sti.TVALID = 1'b0; sti.TDATA = '0; sti.TLAST = 1'b0; sto.TREADY = 1'b1;
    repeat (3) step();
    ARESET = 1'b0;
    chk("rst_acq", 64'(sts_acq), 64'(0));
    chk("rst_arm", 64'(sts_arm), 64'(0));
    chk("rst_trg", 64'(sts_trg), 64'(0));
    chk("rst_pre", 64'(sts_pre), 64'(0));
    chk("rst_pst", 64'(sts_pst), 64'(0));
    chk("rst_tvalid", 64'(sto.TVALID), 64'(0));
    chk("rst_tlast", 64'(sto.TLAST), 64'(0));
    chk("rst_tdata", 64'(sto.TDATA), 64'(0));

    // Basic acquisition: 4 pre, trigger on the 10th sample, 3 post.
    cfg_pre = 4; cfg_pst = 2;
    seq = 100; sti.TDATA = DWI'(seq); sti.TVALID = 1'b1;
    got_d.delete(); got_l.delete();
    ctl_acq = 1'b1; step(); ctl_acq = 1'b0;
    repeat (9) step();
    ctl_trg = 1'b1; step(); ctl_trg = 1'b0;
    repeat (6) step();
    chk("t1_count", 64'(got_d.size()), 64'(13));
    foreach (got_d[i]) begin
      chk("t1_data", 64'(got_d[i]), 64'(101 + i));
      chk("t1_last", 64'(got_l[i]), 64'(i == 12));
    end
    chk("t1_pre", 64'(sts_pre), 64'(10));
    chk("t1_pst", 64'(sts_pst), 64'(2));
    chk("t1_idle", 64'(sts_acq), 64'(0));

    // Trigger during PRE is ignored.
    cfg_pre = 8; cfg_pst = 1;
    got_d.delete(); got_l.delete();
    base = seq;
    ctl_acq = 1'b1; step(); ctl_acq = 1'b0;
    repeat (2) step();
    ctl_trg = 1'b1; step(); ctl_trg = 1'b0;
    repeat (9) step();
    chk("t2_arm", 64'(sts_arm), 64'(1));
    chk("t2_trg", 64'(sts_trg), 64'(0));
    chk("t2_pre", 64'(sts_pre), 64'(12));
    ctl_trg = 1'b1; step(); ctl_trg = 1'b0;
    chk("t2_post", 64'(sts_trg), 64'(1));
    repeat (4) step();
    chk("t2_count", 64'(got_d.size()), 64'(15));
    chk("t2_nlast", 64'(n_last()), 64'(1));
    if (got_d.size() == 15) begin
      chk("t2_first", 64'(got_d[0]), 64'(base + 1));
      chk("t2_lastd", 64'(got_d[14]), 64'(base + 15));
      chk("t2_lastf", 64'(got_l[14]), 64'(1));
    end
    chk("t2_pst", 64'(sts_pst), 64'(1));
    chk("t2_idle", 64'(sts_acq), 64'(0));

    // Random downstream backpressure.
    cfg_pre = 2; cfg_pst = 5;
    got_d.delete(); got_l.delete();
    base = seq; trg_done = 1'b0; done = 1'b0; post_first = 0;
    stab_on = 1'b1; p_stall = 1'b0;
    ctl_acq = 1'b1; step(); ctl_acq = 1'b0;
    for (int i = 0; i < 400; i++) begin
      int tval;
      bit fire;
      sto.TREADY = 1'($urandom_range(0, 1));
      fire = (!trg_done && i >= 12 && sts_arm);
      tval = seq;
      if (fire) begin
        ctl_trg = 1'b1;
        trg_done = 1'b1;
      end
      step();
      ctl_trg = 1'b0;
      if (fire) post_first = last_in_x ? tval + 1 : tval;
      if (trg_done && !sts_acq && !sto.TVALID) begin
        done = 1'b1;
        break;
      end
    end
    stab_on = 1'b0; sto.TREADY = 1'b1;
    step();
    chk("t3_done", 64'(done), 64'(1));
    chk("t3_nlast", 64'(n_last()), 64'(1));
    if (got_d.size() > 0) begin
      chk("t3_first", 64'(got_d[0]), 64'(base + 1));
      foreach (got_d[i]) chk("t3_seq", 64'(got_d[i]), 64'(base + 1 + i));
      chk("t3_lastf", 64'(got_l[got_d.size() - 1]), 64'(1));
      chk("t3_npost", 64'(got_d[got_d.size() - 1] - post_first + 1), 64'(6));
    end else begin
      chk("t3_any", 64'(got_d.size()), 64'(1));
    end
    chk("t3_pst", 64'(sts_pst), 64'(5));

    // Continuous mode, trigger every 3 cycles.
    cfg_con = 1'b1; cfg_pre = 0; cfg_pst = 0;
    got_d.delete(); got_l.delete();
    pre_on_last = 1'b1;
    ctl_acq = 1'b1; step(); ctl_acq = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      ctl_trg = 1'b1; step(); ctl_trg = 1'b0;
      repeat (2) step();
    end
    ctl_stp = 1'b1; step(); ctl_stp = 1'b0;
    repeat (2) step();
    pre_on_last = 1'b0; cfg_con = 1'b0;
    chk("t4_nlast", 64'(n_last()), 64'(4));
    chk("t4_idle", 64'(sts_acq), 64'(0));

    // Stop and trigger together in ARM.
    cfg_pre = 1; cfg_pst = 3;
    got_d.delete(); got_l.delete();
    trg_seen = 1'b0; base = seq;
    ctl_acq = 1'b1; step(); ctl_acq = 1'b0;
    step();
    chk("t5_arm", 64'(sts_arm), 64'(1));
    ctl_stp = 1'b1; ctl_trg = 1'b1; step(); ctl_stp = 1'b0; ctl_trg = 1'b0;
    chk("t5_idle", 64'(sts_acq), 64'(0));
    chk("t5_trg", 64'(sts_trg), 64'(0));
    repeat (3) step();
    chk("t5_trgseen", 64'(trg_seen), 64'(0));
    chk("t5_nlast", 64'(n_last()), 64'(0));
    chk("t5_pst", 64'(sts_pst), 64'(0));
    chk("t5_deliv", 64'((got_d.size() > 0) ? got_d[0] : -1), 64'(base + 1));

    // Soft reset in POST with the output stalled.
    cfg_pre = 0; sto.TREADY = 1'b0;
    ctl_acq = 1'b1; step(); ctl_acq = 1'b0;
    step();
    ctl_trg = 1'b1; step(); ctl_trg = 1'b0;
    chk("t6_post", 64'(sts_trg), 64'(1));
    chk("t6_vld", 64'(sto.TVALID), 64'(1));
    chk("t6_pre", 64'(sts_pre), 64'(1));
    ctl_rst = 1'b1; step(); ctl_rst = 1'b0;
    chk("t6_flush", 64'(sto.TVALID), 64'(0));
    chk("t6_pre0", 64'(sts_pre), 64'(0));
    chk("t6_pst0", 64'(sts_pst), 64'(0));
    chk("t6_idle", 64'(sts_acq), 64'(0));
    sto.TREADY = 1'b1;

`ifdef SCOPE_ACQ_TIMESTAMP_EN
    // Trigger accepted when the cycle counter reads 100.
    ctl_rst = 1'b1; step(); ctl_rst = 1'b0;
    cfg_pre = 0; cfg_pst = 0; cfg_con = 1'b0;
    ctl_acq = 1'b1; step(); ctl_acq = 1'b0;
    step();
    repeat (98) step();
    ctl_trg = 1'b1; step(); ctl_trg = 1'b0;
    chk("ts_trg", 64'(sts_tmr_trg), 64'(100));
    repeat (3) step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
